// File: rtl/reorder_buffer.sv
// Circular reorder buffer: allocates entries at issue, collects ALU/LSB results,
// retires one instruction per cycle in program order and flushes on branch mispredict.
module reorder_buffer #(
  parameter int ROB_INDEX_BIT = 4
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic                     rdy_in,
  input  logic                     issue_valid,
  input  logic [1:0]               issue_type,
  input  logic [4:0]               issue_rd,
  input  logic                     issue_pred_taken,
  output logic [ROB_INDEX_BIT-1:0] issue_rob_id,
  output logic                     full,
  input  logic                     alu_wb_valid,
  input  logic [ROB_INDEX_BIT-1:0] alu_wb_rob_id,
  input  logic [31:0]              alu_wb_value,
  input  logic                     alu_wb_taken,
  input  logic [31:0]              alu_wb_target,
  input  logic                     lsb_wb_valid,
  input  logic [ROB_INDEX_BIT-1:0] lsb_wb_rob_id,
  input  logic [31:0]              lsb_wb_value,
  input  logic [ROB_INDEX_BIT-1:0] qry1_id,
  input  logic [ROB_INDEX_BIT-1:0] qry2_id,
  output logic                     qry1_ready,
  output logic                     qry2_ready,
  output logic [31:0]              qry1_value,
  output logic [31:0]              qry2_value,
  output logic [4:0]               set_value_id,
  output logic [31:0]              set_value,
  output logic [ROB_INDEX_BIT-1:0] set_value_rob_id,
  output logic                     store_commit,
  output logic [ROB_INDEX_BIT-1:0] store_commit_rob_id,
  output logic                     clear,
  output logic [31:0]              clear_pc
);
  localparam int DEPTH = 2 ** ROB_INDEX_BIT;
  localparam logic [ROB_INDEX_BIT:0] CNT_FULL = (ROB_INDEX_BIT + 1)'(DEPTH);
  localparam logic [1:0] TYPE_STORE  = 2'd1;
  localparam logic [1:0] TYPE_BRANCH = 2'd2;

  logic [DEPTH-1:0]         busy_q, busy_d, ready_q, ready_d;
  logic [1:0]               type_q   [DEPTH];
  logic [4:0]               rd_q     [DEPTH];
  logic                     pred_q   [DEPTH];
  logic                     taken_q  [DEPTH];
  logic [31:0]              value_q  [DEPTH];
  logic [31:0]              target_q [DEPTH];
  logic [ROB_INDEX_BIT-1:0] head_q, head_d, tail_q, tail_d;
  logic [ROB_INDEX_BIT:0]   count_q, count_d;

  logic [4:0]               set_value_id_q, set_value_id_d;
  logic [31:0]              set_value_q, set_value_d;
  logic [ROB_INDEX_BIT-1:0] set_value_rob_id_q, set_value_rob_id_d;
  logic                     store_commit_q, store_commit_d;
  logic [ROB_INDEX_BIT-1:0] store_commit_rob_id_q, store_commit_rob_id_d;
  logic                     clear_q, clear_d;
  logic [31:0]              clear_pc_q, clear_pc_d;

  logic can_act, do_alloc, do_commit, mispredict, alu_hit, lsb_hit;

  assign full         = (count_q == CNT_FULL);
  assign issue_rob_id = tail_q;

  // The flush cycle (clear_q high) swallows every issue/writeback/commit.
  assign can_act    = rdy_in && !clear_q;
  assign do_alloc   = can_act && issue_valid && !full;
  assign do_commit  = can_act && busy_q[head_q] && ready_q[head_q];
  assign mispredict = do_commit && (type_q[head_q] == TYPE_BRANCH) &&
                      (taken_q[head_q] != pred_q[head_q]);
  assign alu_hit    = can_act && alu_wb_valid && busy_q[alu_wb_rob_id];
  assign lsb_hit    = can_act && lsb_wb_valid && busy_q[lsb_wb_rob_id] &&
                      !(alu_hit && (alu_wb_rob_id == lsb_wb_rob_id));

  function automatic logic [32:0] lookup(input logic [ROB_INDEX_BIT-1:0] id);
    if (alu_wb_valid && alu_wb_rob_id == id) return {1'b1, alu_wb_value};
    if (lsb_wb_valid && lsb_wb_rob_id == id) return {1'b1, lsb_wb_value};
    return {busy_q[id] && ready_q[id], value_q[id]};
  endfunction

  assign {qry1_ready, qry1_value} = lookup(qry1_id);
  assign {qry2_ready, qry2_value} = lookup(qry2_id);

  always_comb begin
    busy_d  = busy_q;
    ready_d = ready_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (alu_hit) ready_d[alu_wb_rob_id] = 1'b1;
    if (lsb_hit) ready_d[lsb_wb_rob_id] = 1'b1;
    if (do_commit) begin
      busy_d[head_q] = 1'b0;
      head_d = head_q + 1'b1;
    end
    if (do_alloc) begin
      busy_d[tail_q]  = 1'b1;
      ready_d[tail_q] = 1'b0;
      tail_d = tail_q + 1'b1;
    end
    count_d = count_q + (ROB_INDEX_BIT + 1)'(do_alloc) - (ROB_INDEX_BIT + 1)'(do_commit);
    if (mispredict) begin
      busy_d  = '0;
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
  end

  always_comb begin
    set_value_id_d        = set_value_id_q;
    set_value_d           = set_value_q;
    set_value_rob_id_d    = set_value_rob_id_q;
    store_commit_d        = store_commit_q;
    store_commit_rob_id_d = store_commit_rob_id_q;
    clear_d               = clear_q;
    clear_pc_d            = clear_pc_q;
    if (rdy_in) begin
      // Strobes fall back to idle; value/pc buses keep their last contents.
      set_value_id_d = '0;
      store_commit_d = 1'b0;
      clear_d        = 1'b0;
      if (do_commit) begin
        if (type_q[head_q] == TYPE_STORE) begin
          store_commit_d        = 1'b1;
          store_commit_rob_id_d = head_q;
        end else begin
          set_value_id_d     = rd_q[head_q];
          set_value_d        = value_q[head_q];
          set_value_rob_id_d = head_q;
        end
        if (mispredict) begin
          clear_d    = 1'b1;
          clear_pc_d = target_q[head_q];
        end
      end
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      busy_q                <= '0;
      ready_q               <= '0;
      head_q                <= '0;
      tail_q                <= '0;
      count_q               <= '0;
      set_value_id_q        <= '0;
      set_value_q           <= '0;
      set_value_rob_id_q    <= '0;
      store_commit_q        <= 1'b0;
      store_commit_rob_id_q <= '0;
      clear_q               <= 1'b0;
      clear_pc_q            <= '0;
    end else begin
      busy_q                <= busy_d;
      ready_q               <= ready_d;
      head_q                <= head_d;
      tail_q                <= tail_d;
      count_q               <= count_d;
      set_value_id_q        <= set_value_id_d;
      set_value_q           <= set_value_d;
      set_value_rob_id_q    <= set_value_rob_id_d;
      store_commit_q        <= store_commit_d;
      store_commit_rob_id_q <= store_commit_rob_id_d;
      clear_q               <= clear_d;
      clear_pc_q            <= clear_pc_d;
    end
  end

  // Payload storage needs no reset: busy/ready gate every use of it.
  always_ff @(posedge clk_in) begin
    if (do_alloc) begin
      type_q[tail_q]  <= issue_type;
      rd_q[tail_q]    <= issue_rd;
      pred_q[tail_q]  <= issue_pred_taken;
      taken_q[tail_q] <= issue_pred_taken;
    end
    if (alu_hit) begin
      value_q[alu_wb_rob_id]  <= alu_wb_value;
      taken_q[alu_wb_rob_id]  <= alu_wb_taken;
      target_q[alu_wb_rob_id] <= alu_wb_target;
    end
    if (lsb_hit) value_q[lsb_wb_rob_id] <= lsb_wb_value;
  end

  assign set_value_id        = set_value_id_q;
  assign set_value           = set_value_q;
  assign set_value_rob_id    = set_value_rob_id_q;
  assign store_commit        = store_commit_q;
  assign store_commit_rob_id = store_commit_rob_id_q;
  assign clear               = clear_q;
  assign clear_pc            = clear_pc_q;
endmodule

// File: tb/tb_reorder_buffer.sv
// Bench for reorder_buffer: directed vector table, hand-written corner sequences
// and a randomized run against a queue-based program-order model.
module tb_reorder_buffer;
  logic        clk = 1'b0, rst = 1'b0, rdy = 1'b1;
  logic        iv;
  logic [1:0]  ity;
  logic [4:0]  ird;
  logic        ipred;
  logic [3:0]  irid;
  logic        full;
  logic        av, at, lv;
  logic [3:0]  aid, lid, q1id, q2id;
  logic [31:0] aval, atgt, lval;
  logic        q1r, q2r;
  logic [31:0] q1v, q2v;
  logic [4:0]  svid;
  logic [31:0] sv, cpc;
  logic [3:0]  srid, scid;
  logic        sc, clr;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  reorder_buffer #(.ROB_INDEX_BIT(4)) dut (
    .clk_in(clk), .rst_in(rst), .rdy_in(rdy),
    .issue_valid(iv), .issue_type(ity), .issue_rd(ird), .issue_pred_taken(ipred),
    .issue_rob_id(irid), .full(full),
    .alu_wb_valid(av), .alu_wb_rob_id(aid), .alu_wb_value(aval),
    .alu_wb_taken(at), .alu_wb_target(atgt),
    .lsb_wb_valid(lv), .lsb_wb_rob_id(lid), .lsb_wb_value(lval),
    .qry1_id(q1id), .qry2_id(q2id), .qry1_ready(q1r), .qry2_ready(q2r),
    .qry1_value(q1v), .qry2_value(q2v),
    .set_value_id(svid), .set_value(sv), .set_value_rob_id(srid),
    .store_commit(sc), .store_commit_rob_id(scid), .clear(clr), .clear_pc(cpc)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", nm, act, exp);
    end
  endtask

  task automatic idle();
    iv = 0; ity = 0; ird = 0; ipred = 0;
    av = 0; aid = 0; aval = 0; at = 0; atgt = 0;
    lv = 0; lid = 0; lval = 0; q1id = 0; q2id = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    idle();
    rdy = 1; rst = 1;
    tick();
    rst = 0;
  endtask

  task automatic issue(input logic [1:0] t, input logic [4:0] r, input logic p);
    idle(); iv = 1; ity = t; ird = r; ipred = p;
    tick();
  endtask

  // Directed vector table: inputs applied before an edge, outputs expected after it.
  typedef struct {
    logic        iv;
    logic [4:0]  ird;
    logic        av;
    logic [3:0]  aid;
    logic [31:0] aval;
    logic [4:0]  e_svid;
    logic [31:0] e_sv;
    logic [3:0]  e_srid;
    logic [3:0]  e_irid;
  } vec_t;
  vec_t vt[9];

  // Reference model: program-ordered queue of in-flight instructions.
  typedef struct {
    int          id;
    int          typ;
    int          rd;
    bit          pred;
    bit          rdy;
    logic [31:0] val;
    bit          taken;
    logic [31:0] tgt;
  } ent_t;
  ent_t        mq[$];
  int          m_next;
  bit          m_clr;
  logic [4:0]  e_svid;
  logic [31:0] e_sv, e_cpc;
  logic [3:0]  e_srid, e_scid;
  logic        e_sc, e_clr;

  task automatic model_reset();
    mq.delete(); m_next = 0; m_clr = 0;
    e_svid = 0; e_sv = 0; e_srid = 0; e_sc = 0; e_scid = 0; e_clr = 0; e_cpc = 0;
  endtask

  task automatic model_query(input logic [3:0] id, output logic r, output logic [31:0] v);
    r = 0; v = 0;
    if (av && aid == id) begin r = 1; v = aval; end
    else if (lv && lid == id) begin r = 1; v = lval; end
    else foreach (mq[i]) if (mq[i].id == int'(id) && mq[i].rdy) begin r = 1; v = mq[i].val; end
  endtask

  task automatic model_step();
    bit act, com, mis, al;
    ent_t e;
    act = rdy && !m_clr;
    com = act && mq.size() > 0 && mq[0].rdy;
    al  = act && iv && mq.size() < 16;
    mis = 0;
    if (rdy) begin e_svid = 0; e_sc = 0; e_clr = 0; end
    if (com) begin
      e = mq[0];
      if (e.typ == 1) begin e_sc = 1; e_scid = 4'(e.id); end
      else begin
        e_svid = 5'(e.rd); e_sv = e.val; e_srid = 4'(e.id);
        if (e.typ == 2 && e.taken != e.pred) begin mis = 1; e_clr = 1; e_cpc = e.tgt; end
      end
    end
    if (act) foreach (mq[i]) begin
      if (av && mq[i].id == int'(aid)) begin
        mq[i].rdy = 1; mq[i].val = aval; mq[i].taken = at; mq[i].tgt = atgt;
      end else if (lv && mq[i].id == int'(lid)) begin
        mq[i].rdy = 1; mq[i].val = lval;
      end
    end
    if (com) void'(mq.pop_front());
    if (al) begin
      mq.push_back('{m_next, int'(ity), int'(ird), ipred, 1'b0, 32'd0, ipred, 32'd0});
      m_next = (m_next + 1) % 16;
    end
    if (mis) begin mq.delete(); m_next = 0; end
    if (rdy) m_clr = mis;
  endtask

  initial begin
    #400000;
    $display("FAIL timeout: simulation did not finish, required finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic        er;
    logic [31:0] ev;
    vt[0] = '{1'b1, 5'd1, 1'b0, 4'd0, 32'd0,  5'd0, 32'd0,  4'd0, 4'd1};
    vt[1] = '{1'b1, 5'd2, 1'b0, 4'd0, 32'd0,  5'd0, 32'd0,  4'd0, 4'd2};
    vt[2] = '{1'b1, 5'd3, 1'b0, 4'd0, 32'd0,  5'd0, 32'd0,  4'd0, 4'd3};
    vt[3] = '{1'b0, 5'd0, 1'b1, 4'd2, 32'd30, 5'd0, 32'd0,  4'd0, 4'd3};
    vt[4] = '{1'b0, 5'd0, 1'b1, 4'd0, 32'd10, 5'd0, 32'd0,  4'd0, 4'd3};
    vt[5] = '{1'b0, 5'd0, 1'b1, 4'd1, 32'd20, 5'd1, 32'd10, 4'd0, 4'd3};
    vt[6] = '{1'b0, 5'd0, 1'b0, 4'd0, 32'd0,  5'd2, 32'd20, 4'd1, 4'd3};
    vt[7] = '{1'b0, 5'd0, 1'b0, 4'd0, 32'd0,  5'd3, 32'd30, 4'd2, 4'd3};
    vt[8] = '{1'b0, 5'd0, 1'b0, 4'd0, 32'd0,  5'd0, 32'd30, 4'd2, 4'd3};

    @(negedge clk);
    do_reset();
    chk("reset set_value_id", svid, 0);
    chk("reset set_value", sv, 0);
    chk("reset store_commit", sc, 0);
    chk("reset clear", clr, 0);
    chk("reset clear_pc", cpc, 0);
    chk("reset full", full, 0);
    chk("reset issue_rob_id", irid, 0);

    // In-order commit of out-of-order writebacks.
    foreach (vt[k]) begin
      idle();
      iv = vt[k].iv; ird = vt[k].ird; av = vt[k].av; aid = vt[k].aid; aval = vt[k].aval;
      tick();
      $display("vec %0d: set_value_id=%0d set_value=%0d rob_id=%0d issue_rob_id=%0d",
               k, svid, sv, srid, irid);
      chk($sformatf("vec%0d set_value_id", k), svid, vt[k].e_svid);
      chk($sformatf("vec%0d set_value", k), sv, vt[k].e_sv);
      chk($sformatf("vec%0d issue_rob_id", k), irid, vt[k].e_irid);
      if (vt[k].e_svid != 0) chk($sformatf("vec%0d set_value_rob_id", k), srid, vt[k].e_srid);
    end

    // Fill, wrap with simultaneous commit+issue, full, ignored issue while full.
    do_reset();
    for (int i = 0; i < 15; i++) issue(2'd0, 5'(i + 1), 1'b0);
    chk("fill15 issue_rob_id", irid, 15);
    chk("fill15 full", full, 0);
    idle(); av = 1; aid = 0; aval = 32'h77; tick();
    issue(2'd0, 5'd20, 1'b0);
    chk("wrap commit set_value_id", svid, 1);
    chk("wrap tail issue_rob_id", irid, 0);
    chk("wrap count full", full, 0);
    issue(2'd0, 5'd21, 1'b0);
    chk("full after 16", full, 1);
    chk("full issue_rob_id", irid, 1);
    idle(); iv = 1; av = 1; aid = 1; aval = 32'h88; tick();
    chk("17th issue ignored id", irid, 1);
    chk("17th issue full", full, 1);
    issue(2'd0, 5'd22, 1'b0);
    chk("issue while full ignored id", irid, 1);
    chk("commit while full", svid, 2);
    chk("full drops after commit", full, 0);

    // Branch mispredict flush.
    do_reset();
    issue(2'd2, 5'd5, 1'b0);
    for (int i = 0; i < 4; i++) issue(2'd0, 5'(6 + i), 1'b0);
    idle(); av = 1; aid = 1; aval = 1; lv = 1; lid = 2; lval = 2; tick();
    idle(); av = 1; aid = 3; aval = 3; lv = 1; lid = 4; lval = 4; tick();
    idle(); iv = 1; av = 1; aid = 0; aval = 32'h44; at = 1; atgt = 32'h1000; tick();
    idle(); tick();
    chk("flush clear", clr, 1);
    chk("flush clear_pc", cpc, 32'h1000);
    chk("flush link set_value_id", svid, 5);
    chk("flush link set_value", sv, 32'h44);
    chk("flush full", full, 0);
    chk("flush issue_rob_id", irid, 0);
    idle(); iv = 1; av = 1; aid = 1; aval = 9; tick();
    chk("clear one cycle", clr, 0);
    chk("issue ignored in clear", irid, 0);
    for (int i = 0; i < 3; i++) begin
      idle(); tick();
      chk($sformatf("no young commit %0d", i), svid, 0);
    end

    // Same-cycle writeback bypass on query.
    do_reset();
    issue(2'd0, 5'd1, 1'b0);
    issue(2'd0, 5'd2, 1'b0);
    idle(); av = 1; aid = 0; aval = 32'hDEAD; q1id = 0; q2id = 1;
    #1;
    chk("bypass qry1_ready", q1r, 1);
    chk("bypass qry1_value", q1v, 32'hDEAD);
    chk("pending qry2_ready", q2r, 0);
    tick();

    // Store commit through the LSB port, then rdy_in freeze, then async reset.
    do_reset();
    issue(2'd0, 5'd4, 1'b0);
    issue(2'd1, 5'd0, 1'b0);
    idle(); av = 1; aid = 0; aval = 32'h40; lv = 1; lid = 1; lval = 32'h50; tick();
    idle(); tick();
    chk("pre-store reg commit", svid, 4);
    idle(); tick();
    chk("store_commit pulse", sc, 1);
    chk("store_commit_rob_id", scid, 1);
    chk("store set_value_id", svid, 0);
    issue(2'd0, 5'd1, 1'b0);
    chk("store pulse ends", sc, 0);
    issue(2'd0, 5'd2, 1'b0);
    idle(); av = 1; aid = 2; aval = 32'h11; lv = 1; lid = 3; lval = 32'h22; tick();
    idle(); tick();
    chk("pre-freeze commit", svid, 1);
    for (int i = 0; i < 3; i++) begin
      idle(); rdy = 0; iv = 1; tick();
      chk($sformatf("freeze%0d set_value_id", i), svid, 1);
      chk($sformatf("freeze%0d set_value", i), sv, 32'h11);
      chk($sformatf("freeze%0d issue_rob_id", i), irid, 4);
    end
    rdy = 1; idle(); tick();
    chk("post-freeze commit", svid, 2);
    chk("post-freeze value", sv, 32'h22);
    issue(2'd0, 5'd3, 1'b0);
    #2 rst = 1;
    #1;
    chk("async rst set_value_id", svid, 0);
    chk("async rst set_value", sv, 0);
    chk("async rst set_value_rob_id", srid, 0);
    chk("async rst store_commit_rob_id", scid, 0);
    chk("async rst clear_pc", cpc, 0);
    chk("async rst full", full, 0);
    chk("async rst issue_rob_id", irid, 0);
    @(negedge clk);
    rst = 0;

    // Randomized run against the program-order model.
    do_reset();
    model_reset();
    for (int c = 0; c < 3000; c++) begin
      idle();
      rdy   = ($urandom % 10) != 0;
      iv    = ($urandom % 3) != 0;
      ity   = 2'($urandom % 3);
      ird   = 5'($urandom);
      ipred = 1'($urandom);
      av    = 1'($urandom);
      aid   = (mq.size() > 0 && ($urandom % 8) != 0) ? 4'(mq[$urandom_range(0, mq.size() - 1)].id) : 4'($urandom);
      aval  = $urandom;
      atgt  = $urandom;
      lv    = 1'($urandom);
      lid   = (mq.size() > 0 && ($urandom % 8) != 0) ? 4'(mq[$urandom_range(0, mq.size() - 1)].id) : 4'($urandom);
      lval  = $urandom;
      if (av && lid == aid) lv = 0;
      q1id  = 4'($urandom);
      q2id  = 4'($urandom);
      #1;
      for (int i = 0; i < mq.size(); i++)
        if (mq[i].id == int'(aid)) at = (($urandom % 4) == 0) ? !mq[i].pred : mq[i].pred;
      #1;
      chk("rand full", full, 32'(mq.size() == 16));
      chk("rand issue_rob_id", irid, 32'(m_next));
      model_query(q1id, er, ev);
      chk("rand qry1_ready", q1r, 32'(er));
      if (er) chk("rand qry1_value", q1v, ev);
      model_query(q2id, er, ev);
      chk("rand qry2_ready", q2r, 32'(er));
      if (er) chk("rand qry2_value", q2v, ev);
      model_step();
      tick();
      chk("rand set_value_id", svid, 32'(e_svid));
      chk("rand set_value", sv, e_sv);
      chk("rand store_commit", sc, 32'(e_sc));
      chk("rand clear", clr, 32'(e_clr));
      chk("rand clear_pc", cpc, e_cpc);
      if (e_svid != 0) chk("rand set_value_rob_id", srid, 32'(e_srid));
      if (e_sc) chk("rand store_commit_rob_id", scid, 32'(e_scid));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
